demux_1_4_stream: RTL and testbench

- 1-to-4 stream demultiplexer: the write-side counterpart of the team's 4:1 selector.
- Takes one valid/ready input stream plus a 2-bit destination select (s0, s1) and routes each accepted word to exactly one of four output channels.
- Routing encoding matches the existing 4:1 mux: channel index = {s0,s1}, so s0=1,s1=0 -> out2.
- A one-entry registered stage sits between input and outputs: 1-cycle latency, full throughput.

---
 rtl/demux_1_4_stream.sv | 100 ++++++++++
 tb/tb_demux_1_4_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: 1-to-4 valid/ready stream demultiplexer with a one-entry
// registered holding stage (1-cycle latency, full throughput).
// Channel index = {s0,s1}.
// Optional macro DEMUX_CNT_EN adds per-channel transfer counters cnt0..cnt3.
module demux_1_4_stream #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s0,
  input  logic             s1,
  output logic [W-1:0]     out0,
  output logic [W-1:0]     out1,
  output logic [W-1:0]     out2,
  output logic [W-1:0]     out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  // Counter width must be meaningful even when the counters are compiled out.
  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("demux_1_4_stream: CNT_W must be at least 1");
  end

  logic         full;
  logic [W-1:0] data;
  logic [1:0]   dest;
  logic         in_fire;
  logic         out_fire;

  // Handshake decode; in_ready passes the destination's ready straight through.
  always_comb begin
    out_fire = full & out_ready[dest];
    in_ready = ~full | out_ready[dest];
    in_fire  = in_valid & in_ready;
  end

  // Holding register: a new word may replace the departing one in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
      dest <= 2'b00;
    end else begin
      if (in_fire) begin
        full <= 1'b1;
        data <= in_data;
        dest <= {s0, s1};
      end else if (out_fire) begin
        full <= 1'b0;
      end
    end
  end

  // Output steering: only the destination channel sees data and valid.
  always_comb begin
    out_valid = 4'b0000;
    out0      = '0;
    out1      = '0;
    out2      = '0;
    out3      = '0;
    case (dest)
      2'd0: begin out0 = data; out_valid[0] = full; end
      2'd1: begin out1 = data; out_valid[1] = full; end
      2'd2: begin out2 = data; out_valid[2] = full; end
      default: begin out3 = data; out_valid[3] = full; end
    endcase
  end

`ifdef DEMUX_CNT_EN
  // Per-channel delivered-word counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (out_fire) begin
      case (dest)
        2'd0: cnt0 <= cnt0 + CNT_W'(1);
        2'd1: cnt1 <= cnt1 + CNT_W'(1);
        2'd2: cnt2 <= cnt2 + CNT_W'(1);
        default: cnt3 <= cnt3 + CNT_W'(1);
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Self-checking bench for demux_1_4_stream (directed scenarios plus randomized
// traffic against a queue-based reference model). Counter test needs DEMUX_CNT_EN.
module tb_demux_1_4_stream;

  localparam int unsigned W        = 8;
  localparam int unsigned TB_CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         s0 = 1'b0;
  logic         s1 = 1'b0;
  logic [W-1:0] out0, out1, out2, out3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'b0000;
`ifdef DEMUX_CNT_EN
  logic [TB_CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int nchk = 0;
  int nerr = 0;

  demux_1_4_stream #(.W(W), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .s0(s0), .s1(s1),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef DEMUX_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: words accepted but not yet delivered, plus the last
  // accepted word (which keeps driving its channel's data lines).
  typedef struct {
    logic [W-1:0] d;
    int           ch;
  } item_t;

  item_t        hold[$];
  logic [W-1:0] last_d;
  int           last_ch;
  int           delivered[4];

  function automatic void model_clear();
    hold.delete();
    last_d  = '0;
    last_ch = 0;
    for (int k = 0; k < 4; k++) delivered[k] = 0;
  endfunction

  function automatic logic exp_ready();
    return (hold.size() == 0) || out_ready[hold[0].ch];
  endfunction

  function automatic logic [3:0] exp_valid();
    if (hold.size() == 0) return 4'b0000;
    return 4'(1 << hold[0].ch);
  endfunction

  function automatic logic [W-1:0] exp_out(int k);
    return (last_ch == k) ? last_d : '0;
  endfunction

  function automatic logic [W-1:0] get_out(int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      default: return out3;
    endcase
  endfunction

  // Apply inputs and advance to the sampling point (falling edge).
  task automatic set_in(input logic v, input logic [W-1:0] d,
                        input logic a, input logic b, input logic [3:0] r);
    in_valid  = v;
    in_data   = d;
    s0        = a;
    s1        = b;
    out_ready = r;
    @(negedge clk);
  endtask

  // Rising edge: update the model from the inputs seen at this edge.
  task automatic tick();
    logic ofire, ifire;
    @(posedge clk);
    ofire = (hold.size() != 0) && out_ready[hold[0].ch];
    ifire = in_valid && ((hold.size() == 0) || ofire);
    if (ofire) begin
      delivered[hold[0].ch]++;
      void'(hold.pop_front());
    end
    if (ifire) begin
      hold.push_back('{d: in_data, ch: int'({s0, s1})});
      last_d  = in_data;
      last_ch = int'({s0, s1});
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    nchk++;
    if (out_valid !== 4'b0000 || out0 !== 8'h00 || out1 !== 8'h00 ||
        out2 !== 8'h00 || out3 !== 8'h00) begin
      nerr++;
      $display("FAIL reset_idle: out_valid=%b outs=%h %h %h %h required 0000 and 00",
               out_valid, out0, out1, out2, out3);
    end
    rst_n = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    // Load a word that stalls, then reset asynchronously mid-transfer.
    set_in(1'b1, 8'hF0, 1'b1, 1'b1, 4'b0000);
    tick();
    nchk++;
    if (out_valid !== 4'b1000 || out3 !== 8'hF0) begin
      nerr++; $display("FAIL reset_preload: out_valid=%b out3=%h required 1000 f0", out_valid, out3);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_clear();
    nchk++;
    if (out_valid !== 4'b0000 || out0 !== 8'h00 || out1 !== 8'h00 ||
        out2 !== 8'h00 || out3 !== 8'h00) begin
      nerr++;
      $display("FAIL reset_async: out_valid=%b outs=%h %h %h %h required 0000 and 00",
               out_valid, out0, out1, out2, out3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nchk++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_mid_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [W-1:0] wd [4];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    for (int i = 0; i <= 4; i++) begin
      logic [1:0] sel;
      sel = 2'(i);
      if (i < 4) set_in(1'b1, wd[i], sel[1], sel[0], 4'b1111);
      else       set_in(1'b0, 8'h00, 1'b0, 1'b0, 4'b1111);
      nchk++;
      if (in_ready !== 1'b1) begin
        nerr++; $display("FAIL route_ready_%0d: in_ready=%b required 1", i, in_ready);
      end
      if (i > 0) begin
        nchk++;
        if (out_valid !== 4'(1 << (i - 1)) || get_out(i - 1) !== wd[i - 1]) begin
          nerr++;
          $display("FAIL route_ch%0d: out_valid=%b data=%h required %b %h",
                   i - 1, out_valid, get_out(i - 1), 4'(1 << (i - 1)), wd[i - 1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    set_in(1'b1, 8'hA5, 1'b1, 1'b0, 4'b1011);
    tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 8'h5A, 1'b0, 1'b1, 4'b1011);
      nchk++;
      if (out_valid !== 4'b0100 || out2 !== 8'hA5 || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold_%0d: out_valid=%b out2=%h in_ready=%b required 0100 a5 0",
                 c, out_valid, out2, in_ready);
      end
      tick();
    end
    set_in(1'b1, 8'h5A, 1'b0, 1'b1, 4'b1111);
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 4'b0100) begin
      nerr++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b required 1 0100", in_ready, out_valid);
    end
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 4'b1111);
    nchk++;
    if (out_valid !== 4'b0010 || out1 !== 8'h5A || out2 !== 8'h00) begin
      nerr++;
      $display("FAIL stall_next: out_valid=%b out1=%h out2=%h required 0010 5a 00",
               out_valid, out1, out2);
    end
    tick();
  endtask

  task automatic test_wrong_channel();
    set_in(1'b1, 8'h3C, 1'b0, 1'b1, 4'b1111);
    tick();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 8'h99, 1'b1, 1'b1, 4'b1101);
      nchk++;
      if (out_valid !== 4'b0010 || out1 !== 8'h3C || in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL wrong_ch_%0d: out_valid=%b out1=%h in_ready=%b required 0010 3c 0",
                 c, out_valid, out1, in_ready);
      end
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 4'b1111);
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 8'hC3, 1'b1, 1'b1, 4'b1111);
    tick();
    set_in(1'b1, 8'h7E, 1'b0, 1'b0, 4'b1000);
    nchk++;
    if (out_valid !== 4'b1000 || out3 !== 8'hC3 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_first: out_valid=%b out3=%h in_ready=%b required 1000 c3 1",
               out_valid, out3, in_ready);
    end
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 4'b1111);
    nchk++;
    if (out_valid !== 4'b0001 || out0 !== 8'h7E || out3 !== 8'h00) begin
      nerr++;
      $display("FAIL b2b_swap: out_valid=%b out0=%h out3=%h required 0001 7e 00",
               out_valid, out0, out3);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom));
      nchk++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid()) begin
        nerr++;
        $display("FAIL rand_ctl_%0d: in_ready=%b out_valid=%b required %b %b",
                 c, in_ready, out_valid, exp_ready(), exp_valid());
      end
      for (int k = 0; k < 4; k++) begin
        nchk++;
        if (get_out(k) !== exp_out(k)) begin
          nerr++;
          $display("FAIL rand_out%0d_%0d: got %h required %h", k, c, get_out(k), exp_out(k));
        end
      end
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 4'b1111);
    tick();
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, W'(i), 1'b0, 1'b1, 4'b1111);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 4'b1111);
    tick();
    nchk++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd1 || cnt2 !== 4'd0 || cnt3 !== 4'd0) begin
      nerr++;
      $display("FAIL cnt_wrap: cnt=%0d %0d %0d %0d required 0 1 0 0", cnt0, cnt1, cnt2, cnt3);
    end
    nchk++;
    if (cnt1 !== 4'(delivered[1] % 16)) begin
      nerr++; $display("FAIL cnt_model: cnt1=%0d required %0d", cnt1, delivered[1] % 16);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_stall();
    test_wrong_channel();
    test_back_to_back();
    test_random();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
